pid_channel_scheduler: RTL and testbench
========================================

Name: pid_channel_scheduler

Overview:
Time-multiplexes N_CH independent PID/threshold control channels over one shared, fully pipelined 64-bit floating-point PID datapath. There is one datapath instance per block.
- On each simulation step pulse, issues every channel once (one issue per cycle) together with its stored previous input and output.
- Retires results by tag, updates per-channel state, and pulses done_sig when the whole step completes.
- Handles the first-step initial-value mode (datapath outputs G*x) that is armed by control_valuation_sig.

Parameters:
N_CH, 4, number of channels multiplexed (2..16)
CW, 2, channel index width, equal to clog2(N_CH)
DP_LAT, 24, fixed datapath latency in cycles from dp_sta to dp_done (at least 1)
W, 64, data word width (IEEE double)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
rst_user  in  1  synchronous user clear of channel state, active-high
sta  in  1  step-start pulse
control_valuation_sig  in  1  arm initial-value mode for the next step
x_flat  in  N_CH*W  channel inputs; channel k occupies bits [k*W +: W]
dp_sta  out  1  issue strobe to datapath
dp_ch  out  CW  channel tag of the issued operand set
dp_x  out  W  current input x[k]
dp_x_prev  out  W  previous-step x[k]
dp_y_prev  out  W  previous-step y[k]
dp_init  out  1  initial-value mode for this issue
dp_done  in  1  datapath result-valid strobe
dp_y  in  W  datapath result
y_flat  out  N_CH*W  registered per-channel outputs
done_sig  out  1  one-cycle pulse: step complete
busy  out  1  high from sta acceptance until done_sig
err_overrun  out  1  sticky: sta arrived while busy
err_sync  out  1  sticky: dp_done disagreed with the expected tag pipeline

Behaviour:
- Reset (rst=0, async):
  - FSM to IDLE.
  - All y, x_prev and y_prev registers cleared to 0.
  - init_armed, init_done and both error flags cleared to 0.
  - All dp_* outputs, done_sig and busy driven to 0.
- FSM states and transitions:
  - IDLE: sta=1 moves to ISSUE; the issue counter is set to 0 and x_flat is latched into the step snapshot.
  - ISSUE: one channel is issued per cycle (k = 0..N_CH-1). Each issue cycle drives dp_sta=1, dp_ch=k, dp_x=snapshot[k], dp_x_prev=x_prev[k], dp_y_prev=y_prev[k], dp_init=step_init. In the same cycle x_prev[k] is updated to snapshot[k]. After k=N_CH-1 the FSM moves to DRAIN.
  - DRAIN: waits until the retired count equals N_CH, then moves to DONE.
  - DONE: done_sig=1 for exactly one cycle, busy drops, step_init clears, and the FSM returns to IDLE.
- Timing, with sta sampled at edge t:
  - Channel k is issued in cycle t+1+k.
  - Channel k retires in cycle t+1+k+DP_LAT.
  - done_sig is high in cycle t+N_CH+DP_LAT+1.
  - Steps can be issued back to back with sta repeated every N_CH+DP_LAT+2 cycles.
- Tag line:
  - An internal DP_LAT-stage shift register carries {valid, ch} alongside each issue.
  - On an emerging valid tag with dp_done=1: y[ch] and y_prev[ch] are set to dp_y, and the retired count is incremented.
  - A mismatch sets err_sync. This covers dp_done=1 with no valid tag, and a valid tag with dp_done=0. The result is still not written.
- Initial mode:
  - control_valuation_sig=1 while init_done=0 sets init_armed.
  - At sta acceptance, step_init is set to init_armed.
  - At the DONE of an initial step, init_done is set to 1 and init_armed to 0. Later assertions of control_valuation_sig are ignored until rst_user.
- sta while busy: the pulse is ignored and err_overrun is set.
- rst_user=1, in any state:
  - Flush the tag line and return the FSM to IDLE with no done_sig.
  - Clear y, x_prev, y_prev, init_armed and init_done.
  - Error flags are not cleared.
  - rst_user takes priority over a simultaneous sta.
- No arithmetic is performed in this block; words pass through unmodified.

Decomposition:
- Shared package: W, the NaN-free zero constant (64'h0), and the FSM state encoding IDLE/ISSUE/DRAIN/DONE.
- One sub-module, pid_tag_pipe: a parameterised DP_LAT-deep {valid, CW} shift register with synchronous flush.
- The channel register file stays inline.

Test Plan:
- Reset to one step: N_CH=4, DP_LAT=24, stub datapath returns dp_y = dp_x + 1.0, x = {1.0, 2.0, 3.0, 4.0}. Expect dp_sta in cycles t+1..t+4, y = {2.0, 3.0, 4.0, 5.0}, done_sig only in cycle t+29, busy high for t+1..t+28.
- State carry: a second step with x = {5.0, 6.0, 7.0, 8.0}. Expect dp_x_prev = {1.0, 2.0, 3.0, 4.0} and dp_y_prev = {2.0, 3.0, 4.0, 5.0} at the respective issues.
- Initial mode: pulse control_valuation_sig, then sta. Expect dp_init=1 on all 4 issues of that step only; the next step has dp_init=0; a further control_valuation_sig pulse gives dp_init=0.
- Overrun: sta again at t+10 during a step. Expect it ignored, err_overrun=1, done_sig still at t+29 with no second step.
- Sync error: suppress dp_done for channel 2. Expect err_sync=1, y[2] unchanged, done_sig never asserted, FSM stays in DRAIN until rst_user.
- rst_user mid-step at t+15. Expect no done_sig, all y=0, FSM in IDLE the next cycle, and the following step shows dp_x_prev=0 and dp_y_prev=0.

Source files
------------

// File: rtl/pid_channel_scheduler_pkg.sv
// Shared types and constants for the PID channel scheduler.
// Word width, zero word and FSM state encoding.
package pid_channel_scheduler_pkg;

  localparam int W = 64;
  localparam logic [W-1:0] ZERO = 64'h0;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/pid_channel_scheduler_tag.sv
// Tag line: DEPTH-deep {valid, ch} shift register.
// Tracks which channel each datapath result belongs to.
module pid_tag_pipe
  import pid_channel_scheduler_pkg::*;
#(
  parameter int DEPTH = 24,
  parameter int CW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_vld,
  input  logic [CW-1:0] in_ch,
  output logic          out_vld,
  output logic [CW-1:0] out_ch
);

  logic [DEPTH-1:0]         vld;
  logic [DEPTH-1:0][CW-1:0] ch;

  // shift one stage per cycle, flush drops every in-flight tag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= '0;
      ch  <= '0;
    end else if (flush) begin
      vld <= '0;
      ch  <= '0;
    end else begin
      vld[0] <= in_vld;
      ch[0]  <= in_ch;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        ch[i]  <= ch[i-1];
      end
    end
  end

  assign out_vld = vld[DEPTH-1];
  assign out_ch  = ch[DEPTH-1];

endmodule

// File: rtl/pid_channel_scheduler.sv
// Time-multiplexes N_CH PID channels over one pipelined datapath.
// Issues each channel once per step and retires results by tag.
module pid_channel_scheduler
  import pid_channel_scheduler_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int CW     = 2,
  parameter int DP_LAT = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rst_user,
  input  logic              sta,
  input  logic              control_valuation_sig,
  input  logic [N_CH*W-1:0] x_flat,
  output logic              dp_sta,
  output logic [CW-1:0]     dp_ch,
  output logic [W-1:0]      dp_x,
  output logic [W-1:0]      dp_x_prev,
  output logic [W-1:0]      dp_y_prev,
  output logic              dp_init,
  input  logic              dp_done,
  input  logic [W-1:0]      dp_y,
  output logic [N_CH*W-1:0] y_flat,
  output logic              done_sig,
  output logic              busy,
  output logic              err_overrun,
  output logic              err_sync
);

  localparam int RW = $clog2(N_CH + 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [RW-1:0] ret;
  logic [W-1:0]  snap   [N_CH];
  logic [W-1:0]  x_prev [N_CH];
  logic [W-1:0]  y_prev [N_CH];
  logic [W-1:0]  y_reg  [N_CH];
  logic          step_init;
  logic          init_armed;
  logic          init_done;
  logic          tag_vld;
  logic [CW-1:0] tag_ch;
  logic          issuing;
  logic          retire;
  logic          last;
  logic          all_ret;

  assign issuing = (state == ISSUE);
  assign retire  = tag_vld & dp_done;
  assign last    = (cnt == CW'(N_CH - 1));
  assign all_ret = (ret == RW'(N_CH)) ||
                   (retire && ret == RW'(N_CH - 1));

  assign dp_sta    = issuing;
  assign dp_ch     = issuing ? cnt : '0;
  assign dp_x      = issuing ? snap[cnt] : ZERO;
  assign dp_x_prev = issuing ? x_prev[cnt] : ZERO;
  assign dp_y_prev = issuing ? y_prev[cnt] : ZERO;
  assign dp_init   = issuing & step_init;
  assign done_sig  = (state == DONE);
  assign busy      = issuing | (state == DRAIN);

  for (genvar k = 0; k < N_CH; k++) begin : g_y
    assign y_flat[k*W +: W] = y_reg[k];
  end

  pid_tag_pipe #(
    .DEPTH (DP_LAT),
    .CW    (CW)
  ) u_tag (
    .clk     (clk),
    .rst     (rst),
    .flush   (rst_user),
    .in_vld  (issuing),
    .in_ch   (cnt),
    .out_vld (tag_vld),
    .out_ch  (tag_ch)
  );

  // step FSM, channel register file, init mode and error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      ret         <= '0;
      step_init   <= 1'b0;
      init_armed  <= 1'b0;
      init_done   <= 1'b0;
      err_overrun <= 1'b0;
      err_sync    <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        snap[k]   <= ZERO;
        x_prev[k] <= ZERO;
        y_prev[k] <= ZERO;
        y_reg[k]  <= ZERO;
      end
    end else if (rst_user) begin
      state      <= IDLE;
      cnt        <= '0;
      ret        <= '0;
      step_init  <= 1'b0;
      init_armed <= 1'b0;
      init_done  <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        x_prev[k] <= ZERO;
        y_prev[k] <= ZERO;
        y_reg[k]  <= ZERO;
      end
    end else begin
      if (control_valuation_sig && !init_done)
        init_armed <= 1'b1;
      if (sta && busy)
        err_overrun <= 1'b1;
      if (tag_vld != dp_done)
        err_sync <= 1'b1;
      if (retire) begin
        y_reg[tag_ch]  <= dp_y;
        y_prev[tag_ch] <= dp_y;
        ret            <= ret + RW'(1);
      end
      unique case (state)
        IDLE: begin
          if (sta) begin
            state     <= ISSUE;
            cnt       <= '0;
            ret       <= '0;
            step_init <= init_armed;
            for (int k = 0; k < N_CH; k++)
              snap[k] <= x_flat[k*W +: W];
          end
        end
        ISSUE: begin
          x_prev[cnt] <= snap[cnt];
          cnt         <= cnt + CW'(1);
          if (last)
            state <= DRAIN;
        end
        DRAIN: begin
          if (all_ret)
            state <= DONE;
        end
        DONE: begin
          state     <= IDLE;
          step_init <= 1'b0;
          if (step_init) begin
            init_done  <= 1'b1;
            init_armed <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_channel_scheduler.sv
// Bench for pid_channel_scheduler with a stub datapath
// that returns x + 1.0 after DP_LAT cycles.
module tb_pid_channel_scheduler;

  localparam int N_CH   = 4;
  localparam int CW     = 2;
  localparam int DP_LAT = 24;
  localparam int W      = 64;

  typedef logic [3:0][63:0] q_t;
  typedef struct {
    q_t x;
    q_t xp;
    q_t yp;
    q_t y;
    bit cvs;
    bit init;
    int ov;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              rst_user = 1'b0;
  logic              sta = 1'b0;
  logic              cvs = 1'b0;
  logic [N_CH*W-1:0] x_flat = '0;
  logic              dp_sta;
  logic [CW-1:0]     dp_ch;
  logic [W-1:0]      dp_x;
  logic [W-1:0]      dp_x_prev;
  logic [W-1:0]      dp_y_prev;
  logic              dp_init;
  logic              dp_done;
  logic [W-1:0]      dp_y;
  logic [N_CH*W-1:0] y_flat;
  logic              done_sig;
  logic              busy;
  logic              err_overrun;
  logic              err_sync;

  int tests = 0;
  int fails = 0;
  bit supp = 1'b0;

  always #5 clk = ~clk;

  pid_channel_scheduler #(
    .N_CH   (N_CH),
    .CW     (CW),
    .DP_LAT (DP_LAT)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .rst_user              (rst_user),
    .sta                   (sta),
    .control_valuation_sig (cvs),
    .x_flat                (x_flat),
    .dp_sta                (dp_sta),
    .dp_ch                 (dp_ch),
    .dp_x                  (dp_x),
    .dp_x_prev             (dp_x_prev),
    .dp_y_prev             (dp_y_prev),
    .dp_init               (dp_init),
    .dp_done               (dp_done),
    .dp_y                  (dp_y),
    .y_flat                (y_flat),
    .done_sig              (done_sig),
    .busy                  (busy),
    .err_overrun           (err_overrun),
    .err_sync              (err_sync)
  );

  // stub datapath
  logic [DP_LAT-1:0] s_vld;
  logic [63:0]       s_y  [DP_LAT];
  logic [1:0]        s_ch [DP_LAT];

  always @(posedge clk) begin
    if (!rst) begin
      s_vld <= '0;
    end else begin
      s_vld <= {s_vld[DP_LAT-2:0], dp_sta};
    end
    s_y[0]  <= $realtobits($bitstoreal(dp_x) + 1.0);
    s_ch[0] <= dp_ch;
    for (int i = 1; i < DP_LAT; i++) begin
      s_y[i]  <= s_y[i-1];
      s_ch[i] <= s_ch[i-1];
    end
  end

  assign dp_done = s_vld[DP_LAT-1] &&
                   !(supp && s_ch[DP_LAT-1] == 2'd2);
  assign dp_y = s_y[DP_LAT-1];

  function automatic q_t q(real a, real b, real c, real e);
    q_t r;
    r[0] = $realtobits(a);
    r[1] = $realtobits(b);
    r[2] = $realtobits(c);
    r[3] = $realtobits(e);
    return r;
  endfunction

  function automatic vec_t mkv(q_t x, q_t xp, q_t yp, q_t y,
                               bit c, bit i, int ov);
    vec_t v;
    v.x = x; v.xp = xp; v.yp = yp; v.y = y;
    v.cvs = c; v.init = i; v.ov = ov;
    return v;
  endfunction

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_step(int id, vec_t v);
    if (v.cvs) begin
      @(negedge clk); cvs = 1'b1;
      @(negedge clk); cvs = 1'b0;
    end
    @(negedge clk);
    x_flat = v.x;
    sta = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (n == 0) sta = 1'b0;
      if (v.ov >= 0 && n == v.ov) sta = 1'b1;
      if (v.ov >= 0 && n == v.ov + 1) sta = 1'b0;
      if (n < 4) begin
        chk($sformatf("s%0d c%0d dp_sta", id, n), dp_sta, 1);
        chk($sformatf("s%0d c%0d dp_ch", id, n), dp_ch, n);
        chk($sformatf("s%0d c%0d dp_x", id, n), dp_x, v.x[n]);
        chk($sformatf("s%0d c%0d dp_x_prev", id, n), dp_x_prev, v.xp[n]);
        chk($sformatf("s%0d c%0d dp_y_prev", id, n), dp_y_prev, v.yp[n]);
        chk($sformatf("s%0d c%0d dp_init", id, n), dp_init, v.init);
      end else begin
        chk($sformatf("s%0d c%0d dp_sta low", id, n), dp_sta, 0);
      end
      chk($sformatf("s%0d c%0d busy", id, n), busy, (n + 1) <= 28);
      chk($sformatf("s%0d c%0d done", id, n), done_sig, (n + 1) == 29);
    end
    chk($sformatf("s%0d y_flat", id), y_flat, v.y);
    if (v.ov >= 0)
      chk($sformatf("s%0d err_overrun", id), err_overrun, 1);
  endtask

  vec_t tv [6];
  bit   seen;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = mkv(q(1, 2, 3, 4), q(0, 0, 0, 0), q(0, 0, 0, 0),
                q(2, 3, 4, 5), 0, 0, -1);
    tv[1] = mkv(q(5, 6, 7, 8), q(1, 2, 3, 4), q(2, 3, 4, 5),
                q(6, 7, 8, 9), 0, 0, -1);
    tv[2] = mkv(q(10, 20, 30, 40), q(5, 6, 7, 8), q(6, 7, 8, 9),
                q(11, 21, 31, 41), 1, 1, -1);
    tv[3] = mkv(q(1, 1, 1, 1), q(10, 20, 30, 40), q(11, 21, 31, 41),
                q(2, 2, 2, 2), 0, 0, -1);
    tv[4] = mkv(q(2, 2, 2, 2), q(1, 1, 1, 1), q(2, 2, 2, 2),
                q(3, 3, 3, 3), 1, 0, -1);
    tv[5] = mkv(q(3, 3, 3, 3), q(2, 2, 2, 2), q(3, 3, 3, 3),
                q(4, 4, 4, 4), 0, 0, 9);

    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("reset dp_sta", dp_sta, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done_sig, 0);
    chk("reset y_flat", y_flat, 0);
    chk("reset err_overrun", err_overrun, 0);
    chk("reset err_sync", err_sync, 0);

    for (int i = 0; i < 6; i++)
      run_step(i, tv[i]);

    chk("no sync error yet", err_sync, 0);

    // sync error: channel 2 result never returns
    supp = 1'b1;
    seen = 1'b0;
    @(negedge clk);
    x_flat = q(9, 9, 9, 9);
    sta = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (n == 0) sta = 1'b0;
      if (done_sig) seen = 1'b1;
    end
    chk("sync no done", seen, 0);
    chk("sync stuck busy", busy, 1);
    chk("sync err_sync", err_sync, 1);
    chk("sync y_flat", y_flat, q(10, 10, 4, 10));
    @(negedge clk); rst_user = 1'b1;
    @(negedge clk); rst_user = 1'b0;
    supp = 1'b0;
    chk("sync clr busy", busy, 0);
    chk("sync clr y_flat", y_flat, 0);
    chk("sync clr done", done_sig, 0);

    // rst_user mid-step, sampled at t+15
    seen = 1'b0;
    @(negedge clk);
    x_flat = q(1, 2, 3, 4);
    sta = 1'b1;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      if (n == 0) sta = 1'b0;
      if (n == 14) rst_user = 1'b1;
    end
    @(posedge clk); #1;
    rst_user = 1'b0;
    chk("rstu busy", busy, 0);
    chk("rstu done", done_sig, 0);
    chk("rstu dp_sta", dp_sta, 0);
    chk("rstu y_flat", y_flat, 0);
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (done_sig || dp_sta) seen = 1'b1;
    end
    chk("rstu quiet", seen, 0);
    run_step(6, mkv(q(4, 3, 2, 1), q(0, 0, 0, 0), q(0, 0, 0, 0),
                    q(5, 4, 3, 2), 0, 0, -1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
